// File: rtl/mem2_writeback_stage_if.sv
// ---------------------------------------------------------------------------
// mem2_writeback_stage_if
//
// Bundles every non-clock signal of the write-back stage:
//   in_*        MEM2 pipeline register outputs (flags, indices, ALU/BRAM data)
//   issue_*     scoreboard set request from the issue stage
//   query_*     hazard query (thread + two source registers) and busy results
//   host_wr_*   host/debug register-file write channel (valid/ready)
//   rf_*        registered register-file write port
//
// master: the surrounding pipeline/host side, which drives requests.
// slave : the write-back stage itself.
// ---------------------------------------------------------------------------
interface mem2_writeback_stage_if #(
    parameter int DATA_WIDTH        = 64,
    parameter int REG_INDEX_BITS    = 5,
    parameter int THREAD_INDEX_BITS = 3
);
    logic                         in_write_back_flag;
    logic                         in_load_word_flag;
    logic [REG_INDEX_BITS-1:0]    in_reg_index;
    logic [THREAD_INDEX_BITS-1:0] in_thread_index;
    logic [DATA_WIDTH-1:0]        in_reg_data;
    logic [DATA_WIDTH-1:0]        in_bram_data;

    logic                         issue_valid;
    logic [THREAD_INDEX_BITS-1:0] issue_thread_index;
    logic [REG_INDEX_BITS-1:0]    issue_reg_index;

    logic [THREAD_INDEX_BITS-1:0] query_thread_index;
    logic [REG_INDEX_BITS-1:0]    query_reg_a;
    logic [REG_INDEX_BITS-1:0]    query_reg_b;
    logic                         query_busy_a;
    logic                         query_busy_b;

    logic                         host_wr_valid;
    logic                         host_wr_ready;
    logic [THREAD_INDEX_BITS-1:0] host_wr_thread_index;
    logic [REG_INDEX_BITS-1:0]    host_wr_reg_index;
    logic [DATA_WIDTH-1:0]        host_wr_data;

    logic                         rf_we;
    logic [THREAD_INDEX_BITS-1:0] rf_thread_index;
    logic [REG_INDEX_BITS-1:0]    rf_reg_index;
    logic [DATA_WIDTH-1:0]        rf_data;

    modport master (
        output in_write_back_flag, in_load_word_flag, in_reg_index, in_thread_index,
               in_reg_data, in_bram_data,
               issue_valid, issue_thread_index, issue_reg_index,
               query_thread_index, query_reg_a, query_reg_b,
               host_wr_valid, host_wr_thread_index, host_wr_reg_index, host_wr_data,
        input  query_busy_a, query_busy_b, host_wr_ready,
               rf_we, rf_thread_index, rf_reg_index, rf_data
    );

    modport slave (
        input  in_write_back_flag, in_load_word_flag, in_reg_index, in_thread_index,
               in_reg_data, in_bram_data,
               issue_valid, issue_thread_index, issue_reg_index,
               query_thread_index, query_reg_a, query_reg_b,
               host_wr_valid, host_wr_thread_index, host_wr_reg_index, host_wr_data,
        output query_busy_a, query_busy_b, host_wr_ready,
               rf_we, rf_thread_index, rf_reg_index, rf_data
    );
endinterface

// File: rtl/mem2_writeback_stage.sv
// ---------------------------------------------------------------------------
// mem2_writeback_stage
//
// Write-back stage of the multithreaded pipeline.
//   - Selects BRAM load data or the ALU result and registers it onto the
//     shared register-file write port (one cycle latency).
//   - Arbitrates that port between the pipeline (always wins, never stalled)
//     and a host/debug valid/ready write channel.
//   - Holds a per-thread pending-write scoreboard: issue sets a bit, a
//     pipeline commit on the rf port clears it. Host writes never touch it.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    mem2_writeback_stage_if.slave (MEM2 inputs, issue, query,
//          host write channel, rf write port)
// ---------------------------------------------------------------------------
module mem2_writeback_stage #(
    parameter int DATA_WIDTH        = 64,
    parameter int REG_INDEX_BITS    = 5,
    parameter int THREAD_INDEX_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    mem2_writeback_stage_if.slave bus
);
    localparam int NUM_ENTRIES = 1 << (THREAD_INDEX_BITS + REG_INDEX_BITS);

    logic                         rf_we_q,           rf_we_d;
    logic                         rf_src_pipe_q,     rf_src_pipe_d;
    logic [THREAD_INDEX_BITS-1:0] rf_thread_index_q, rf_thread_index_d;
    logic [REG_INDEX_BITS-1:0]    rf_reg_index_q,    rf_reg_index_d;
    logic [DATA_WIDTH-1:0]        rf_data_q,         rf_data_d;

    // Scoreboard flattened to one vector indexed by {thread, reg}.
    logic [NUM_ENTRIES-1:0]       pending_q,         pending_d;

    logic [DATA_WIDTH-1:0]        result;

    assign result = bus.in_load_word_flag ? bus.in_bram_data : bus.in_reg_data;

    // The pipeline owns the port whenever it has a write; the host only gets
    // the free cycles, and never while reset is asserted.
    assign bus.host_wr_ready = !reset && !bus.in_write_back_flag;

    // Write-port source selection.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        rf_we_d           = 1'b0;
        rf_src_pipe_d     = rf_src_pipe_q;
        rf_thread_index_d = rf_thread_index_q;
        rf_reg_index_d    = rf_reg_index_q;
        rf_data_d         = rf_data_q;

        if (bus.in_write_back_flag) begin
            rf_we_d           = 1'b1;
            rf_src_pipe_d     = 1'b1;
            rf_thread_index_d = bus.in_thread_index;
            rf_reg_index_d    = bus.in_reg_index;
            rf_data_d         = result;
        end else if (bus.host_wr_valid) begin
            rf_we_d           = 1'b1;
            rf_src_pipe_d     = 1'b0;
            rf_thread_index_d = bus.host_wr_thread_index;
            rf_reg_index_d    = bus.host_wr_reg_index;
            rf_data_d         = bus.host_wr_data;
        end
    end

    // Scoreboard update. The set is applied after the clear so that a set and
    // clear of the same bit on one edge leaves the bit set.
    always_comb begin
        pending_d = pending_q;
        if (rf_we_q && rf_src_pipe_q) begin
            pending_d[{rf_thread_index_q, rf_reg_index_q}] = 1'b0;
        end
        if (bus.issue_valid) begin
            pending_d[{bus.issue_thread_index, bus.issue_reg_index}] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge
        // values, independent of statement order.
        if (reset) begin
            rf_we_q           <= 1'b0;
            rf_src_pipe_q     <= 1'b0;
            rf_thread_index_q <= '0;
            rf_reg_index_q    <= '0;
            rf_data_q         <= '0;
            // NOTE: the scoreboard is a flop array, not a RAM macro, so it can
            // be cleared in one cycle; a stale busy bit would deadlock issue.
            pending_q         <= '0;
        end else begin
            rf_we_q           <= rf_we_d;
            rf_src_pipe_q     <= rf_src_pipe_d;
            rf_thread_index_q <= rf_thread_index_d;
            rf_reg_index_q    <= rf_reg_index_d;
            rf_data_q         <= rf_data_d;
            pending_q         <= pending_d;
        end
    end

    // No bypass: a bit being cleared this cycle still reads busy.
    assign bus.query_busy_a = pending_q[{bus.query_thread_index, bus.query_reg_a}];
    assign bus.query_busy_b = pending_q[{bus.query_thread_index, bus.query_reg_b}];

    assign bus.rf_we           = rf_we_q;
    assign bus.rf_thread_index = rf_thread_index_q;
    assign bus.rf_reg_index    = rf_reg_index_q;
    assign bus.rf_data         = rf_data_q;
endmodule

// File: doc/mem2_writeback_stage.md
Name: mem2_writeback_stage

Overview:
- Final (write-back) stage of the multithreaded 5-stage pipeline. Consumes the MEM1/MEM2 register outputs and selects BRAM load data or ALU result.
- Drives the shared per-thread register-file write port one cycle later.
- Keeps a per-thread pending-write scoreboard: the issue stage sets bits, and this stage clears them on commit.
- Arbitrates the register-file write port between the pipeline (priority) and a host/debug write channel using a valid/ready handshake.

Parameters:
DATA_WIDTH, 64, width of register and BRAM data
REG_INDEX_BITS, 5, register index width (2^REG_INDEX_BITS registers per thread)
THREAD_INDEX_BITS, 3, thread index width (2^THREAD_INDEX_BITS hardware threads)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_write_back_flag  input  1  MEM2 instruction writes a register
in_load_word_flag  input  1  MEM2 instruction is a load; select in_bram_data
in_reg_index  input  REG_INDEX_BITS  destination register
in_thread_index  input  THREAD_INDEX_BITS  owning thread
in_reg_data  input  DATA_WIDTH  ALU/forwarded result
in_bram_data  input  DATA_WIDTH  BRAM read data, valid same cycle as in_* flags
issue_valid  input  1  issue stage dispatches an instruction with a destination
issue_thread_index  input  THREAD_INDEX_BITS  thread of issued instruction
issue_reg_index  input  REG_INDEX_BITS  destination of issued instruction
query_thread_index  input  THREAD_INDEX_BITS  thread for hazard query
query_reg_a  input  REG_INDEX_BITS  source operand A
query_reg_b  input  REG_INDEX_BITS  source operand B
query_busy_a  output  1  pending bit for (query_thread_index, query_reg_a)
query_busy_b  output  1  pending bit for (query_thread_index, query_reg_b)
host_wr_valid  input  1  host write request
host_wr_ready  output  1  host write accepted this cycle when high with valid
host_wr_thread_index  input  THREAD_INDEX_BITS  host target thread
host_wr_reg_index  input  REG_INDEX_BITS  host target register
host_wr_data  input  DATA_WIDTH  host write data
rf_we  output  1  register-file write enable
rf_thread_index  output  THREAD_INDEX_BITS  write thread
rf_reg_index  output  REG_INDEX_BITS  write register
rf_data  output  DATA_WIDTH  write data

Behaviour:
- Data select: when in_load_word_flag=1, result = in_bram_data; otherwise result = in_reg_data. Full-width copy, no extension or arithmetic.
- Write-back register: registered rf_we, rf_thread_index, rf_reg_index, rf_data, plus internal bit rf_src_pipe. Latency from in_* to rf_* is exactly 1 cycle.
- Each cycle, one source loads the write-back register:
  - Pipeline: if in_write_back_flag=1, load result with rf_we<=1 and rf_src_pipe<=1.
  - Host: else if host_wr_valid=1 (and therefore host_wr_ready=1), load host fields with rf_we<=1 and rf_src_pipe<=0.
  - Idle: else rf_we<=0. Index and data fields are don't-care in the spec but hold their last value.
- host_wr_ready = !reset && !in_write_back_flag (combinational). The host holds its request stable until accepted. Pipeline writes are never stalled.
- in_load_word_flag is ignored when in_write_back_flag=0.
- Scoreboard: pending[t][r] is a register array of 2^THREAD_INDEX_BITS × 2^REG_INDEX_BITS bits.
  - Set: issue_valid=1 sets pending[issue_thread_index][issue_reg_index] at the clock edge.
  - Clear: a cycle with rf_we=1 and rf_src_pipe=1 clears pending[rf_thread_index][rf_reg_index] at the end of that cycle.
  - Set and clear of the same bit on the same edge: set wins.
  - Set and clear of different bits on the same edge: both take effect.
  - Host writes never change the scoreboard.
- query_busy_a/b are combinational reads of the current pending bits. There is no bypass: a bit being cleared this cycle still reads 1.
- Clearing an already-clear bit is harmless; setting an already-set bit is harmless. No counting, so issue must not dispatch a second writer to a busy register.
- Reset values: rf_we=0, rf_thread_index=0, rf_reg_index=0, rf_data=0, rf_src_pipe=0, all pending bits=0.
- Reset during operation:
  - Any in-flight write-back is dropped (rf_we=0 on the cycle after the reset edge).
  - Host requests presented during reset are not accepted.
  - Inputs are ignored while reset=1.

Test Plan:
- Load select: wb=1, load=1, thread=3, reg=7, reg_data=0x1111, bram=0xDEADBEEF_CAFEF00D -> next cycle rf_we=1, rf_thread_index=3, rf_reg_index=7, rf_data=0xDEADBEEF_CAFEF00D. Repeat with load=0 -> rf_data=0x1111.
- Scoreboard lifecycle: issue (t2,r5) at cycle 0 -> query (t2,r5) busy=1 from cycle 1. Pipeline wb (t2,r5) at cycle 4 -> rf_we at cycle 5, busy still 1 during cycle 5, busy=0 at cycle 6. Query (t3,r5) busy=0 throughout.
- Set/clear collision: rf commit of (t1,r9) in the same cycle as issue of (t1,r9) -> busy stays 1. Commit of (t1,r9) with issue of (t1,r10) -> r9=0, r10=1.
- Host arbitration: host_wr_valid=1 held across 3 cycles of wb=1 -> host_wr_ready=0 for those 3 cycles, pipeline writes appear in order. Then ready=1, host write (t0,r1,0x55) appears on rf_* next cycle. Scoreboard is unchanged.
- Reset mid-flight: wb=1 at cycle N, reset=1 at cycle N+1 -> rf_we=0 at cycle N+2, all query_busy=0, host_wr_ready=0 while reset=1.
- Back-to-back: 8 consecutive wb writes covering threads 0-7 -> 8 consecutive rf_we cycles with matching thread, reg and data, no bubbles.
